dsp_mode_bits_deserializer: RTL and testbench

Runtime loader for one DSP tile's mode configuration. It accepts a byte-framed configuration stream and checks it. On a good frame it commits the 84-bit MODE_BITS word and drives it to the DSP as unpacked fields (COEFF_0..3, OUTPUT_SELECT, REGISTER_INPUTS). It also serializes the committed word back out on request for readback. It sits between the configuration fabric and the DSP wrapper, and is the runtime counterpart of the synthesis-time MODE_BITS packing.

---
 rtl/dsp_cfg_pkg.sv | 42 ++++
 rtl/dsp_mode_bits_serializer.sv | 86 ++++++++
 rtl/dsp_mode_bits_deserializer.sv | 125 ++++++++++++
 tb/tb_dsp_mode_bits_deserializer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_cfg_pkg.sv
// Shared constants, field map, state types and checksum helper for the DSP
// mode-bits configuration loader and its readback serializer.
package dsp_cfg_pkg;

  localparam logic [7:0] HEADER        = 8'hA5;
  localparam int         MODE_WIDTH    = 84;
  localparam int         PAYLOAD_BYTES = 11;
  localparam int         FRAME_BYTES   = 13;
  localparam int         PAYLOAD_WIDTH = PAYLOAD_BYTES * 8;

  // MODE_BITS field map; bits above REGISTER_INPUTS are pad and must be zero
  localparam int COEFF_W    = 20;
  localparam int COEFF0_LSB = 0;
  localparam int COEFF1_LSB = 20;
  localparam int COEFF2_LSB = 40;
  localparam int COEFF3_LSB = 60;
  localparam int OSEL_LSB   = 80;
  localparam int OSEL_W     = 3;
  localparam int REGIN_BIT  = 83;
  localparam int PAD_LSB    = 84;
  localparam int PAD_W      = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PAYLOAD,
    RX_CHECK,
    RX_APPLY
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  function automatic logic [7:0] xor_bytes(input logic [PAYLOAD_WIDTH-1:0] word);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) acc ^= word[8*i +: 8];
    return acc;
  endfunction

endpackage

// File: rtl/dsp_mode_bits_serializer.sv
// Readback path: snapshots the committed MODE_BITS word on request and streams
// header, payload (LSB byte first) and XOR checksum with valid/ready flow control.
//
// state   | meaning
// TX_IDLE | waiting for a readback request
// TX_SEND | streaming the snapshot frame; first cycle loads the header
module dsp_mode_bits_serializer #(
  parameter logic [7:0] HEADER      = dsp_cfg_pkg::HEADER,
  parameter int         FRAME_BYTES = dsp_cfg_pkg::FRAME_BYTES
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [dsp_cfg_pkg::MODE_WIDTH-1:0] i_mode,
  input  logic                              i_rd_req,
  input  logic                              i_rd_ready,
  output logic [7:0]                        o_rd_data,
  output logic                              o_rd_valid
);
  import dsp_cfg_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  tx_state_e                r_tx_state;
  logic [PAYLOAD_WIDTH-1:0] r_snap;
  logic [7:0]               r_csum;
  logic [3:0]               r_idx;
  logic [7:0]               r_data;
  logic                     r_valid;

  logic [PAYLOAD_WIDTH-1:0] w_word;
  logic [3:0]               w_next_idx;
  logic [7:0]               w_next_byte;

  assign w_word     = {{PAD_W{1'b0}}, i_mode};
  assign w_next_idx = r_idx + 4'd1;

  // Index 0 is the header, 1..11 payload, and anything past that the checksum
  always_comb begin
    w_next_byte = r_csum;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (w_next_idx == 4'(i + 1)) w_next_byte = r_snap[8*i +: 8];
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx_state <= TX_IDLE;
      r_snap     <= '0;
      r_csum     <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (i_rd_req) begin
            r_snap     <= w_word;
            r_csum     <= xor_bytes(w_word);
            r_idx      <= '0;
            r_tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= HEADER;
          end else if (i_rd_ready) begin
            if (r_idx == LAST_IDX) begin
              r_valid    <= 1'b0;
              r_data     <= '0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_next_byte;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign o_rd_data  = r_data;
  assign o_rd_valid = r_valid;

endmodule

// File: rtl/dsp_mode_bits_deserializer.sv
// Runtime MODE_BITS loader: receives a header/payload/checksum byte frame,
// validates it and commits the unpacked fields to the DSP tile.
//
// state      | meaning
// RX_IDLE    | hunting for the header byte; other bytes dropped silently
// RX_PAYLOAD | shifting 11 payload bytes into the shadow, running XOR
// RX_CHECK   | next byte is the checksum; good frame -> APPLY, else error pulse
// RX_APPLY   | one cycle: shadow copied to outputs, done pulse, input stalled
module dsp_mode_bits_deserializer #(
  parameter logic [7:0] HEADER      = dsp_cfg_pkg::HEADER,
  parameter int         FRAME_BYTES = dsp_cfg_pkg::FRAME_BYTES
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  cfg_data_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  output logic [19:0] coeff_0_o,
  output logic [19:0] coeff_1_o,
  output logic [19:0] coeff_2_o,
  output logic [19:0] coeff_3_o,
  output logic [2:0]  output_select_o,
  output logic        register_inputs_o,
  output logic        cfg_done_o,
  output logic        cfg_error_o,
  input  logic        rd_req_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i
);
  import dsp_cfg_pkg::*;

  localparam logic [3:0] LAST_PAYLOAD = 4'(FRAME_BYTES - 3);

  rx_state_e                r_rx_state;
  logic [3:0]               r_cnt;
  logic [PAYLOAD_WIDTH-1:0] r_shadow;
  logic [7:0]               r_xor;
  logic [MODE_WIDTH-1:0]    r_mode;
  logic                     r_ready;
  logic                     r_done;
  logic                     r_error;

  logic w_accept;
  logic w_frame_ok;

  assign w_accept   = cfg_valid_i & r_ready;
  assign w_frame_ok = (cfg_data_i == r_xor) && (r_shadow[PAD_LSB +: PAD_W] == '0);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_xor      <= '0;
      r_mode     <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_accept && (cfg_data_i == HEADER)) begin
            r_cnt      <= '0;
            r_xor      <= '0;
            r_rx_state <= RX_PAYLOAD;
          end
        end
        RX_PAYLOAD: begin
          if (w_accept) begin
            // LSB byte arrives first, so shift in from the top
            r_shadow <= {cfg_data_i, r_shadow[PAYLOAD_WIDTH-1:8]};
            r_xor    <= r_xor ^ cfg_data_i;
            r_cnt    <= r_cnt + 4'd1;
            if (r_cnt == LAST_PAYLOAD) r_rx_state <= RX_CHECK;
          end
        end
        RX_CHECK: begin
          if (w_accept) begin
            if (w_frame_ok) begin
              r_ready    <= 1'b0;
              r_rx_state <= RX_APPLY;
            end else begin
              r_error    <= 1'b1;
              r_rx_state <= RX_IDLE;
            end
          end
        end
        RX_APPLY: begin
          r_mode     <= r_shadow[MODE_WIDTH-1:0];
          r_done     <= 1'b1;
          r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign cfg_ready_o       = r_ready;
  assign cfg_done_o        = r_done;
  assign cfg_error_o       = r_error;
  assign coeff_0_o         = r_mode[COEFF0_LSB +: COEFF_W];
  assign coeff_1_o         = r_mode[COEFF1_LSB +: COEFF_W];
  assign coeff_2_o         = r_mode[COEFF2_LSB +: COEFF_W];
  assign coeff_3_o         = r_mode[COEFF3_LSB +: COEFF_W];
  assign output_select_o   = r_mode[OSEL_LSB +: OSEL_W];
  assign register_inputs_o = r_mode[REGIN_BIT];

  dsp_mode_bits_serializer #(
    .HEADER      (HEADER),
    .FRAME_BYTES (FRAME_BYTES)
  ) u_serializer (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .i_mode     (r_mode),
    .i_rd_req   (rd_req_i),
    .i_rd_ready (rd_ready_i),
    .o_rd_data  (rd_data_o),
    .o_rd_valid (rd_valid_o)
  );

endmodule

// File: tb/tb_dsp_mode_bits_deserializer.sv
// Bench for the MODE_BITS loader: frame-level reference model with a per-cycle
// compare, plus hand-computed literal expectations for the main scenarios.
module tb_dsp_mode_bits_deserializer;

  logic        clock_i     = 1'b0;
  logic        reset_i     = 1'b1;
  logic [7:0]  cfg_data_i  = 8'h00;
  logic        cfg_valid_i = 1'b0;
  logic        rd_req_i    = 1'b0;
  logic        rd_ready_i  = 1'b0;
  logic        cfg_ready_o;
  logic [19:0] coeff_0_o, coeff_1_o, coeff_2_o, coeff_3_o;
  logic [2:0]  output_select_o;
  logic        register_inputs_o;
  logic        cfg_done_o, cfg_error_o;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;

  always #5 clock_i = ~clock_i;

  dsp_mode_bits_deserializer dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .cfg_data_i        (cfg_data_i),
    .cfg_valid_i       (cfg_valid_i),
    .cfg_ready_o       (cfg_ready_o),
    .coeff_0_o         (coeff_0_o),
    .coeff_1_o         (coeff_1_o),
    .coeff_2_o         (coeff_2_o),
    .coeff_3_o         (coeff_3_o),
    .output_select_o   (output_select_o),
    .register_inputs_o (register_inputs_o),
    .cfg_done_o        (cfg_done_o),
    .cfg_error_o       (cfg_error_o),
    .rd_req_i          (rd_req_i),
    .rd_data_o         (rd_data_o),
    .rd_valid_o        (rd_valid_o),
    .rd_ready_i        (rd_ready_i)
  );

  int checks = 0;
  int errors = 0;

  // Frame packed with byte k at [8k +: 8]: header, 11 payload bytes, checksum
  function automatic logic [103:0] mk_frame(input logic [87:0] w);
    logic [103:0] f;
    logic [7:0]   x;
    x = 8'h00;
    f = '0;
    f[7:0] = 8'hA5;
    for (int i = 0; i < 11; i++) begin
      f[8*(i+1) +: 8] = w[8*i +: 8];
      x ^= w[8*i +: 8];
    end
    f[103:96] = x;
    return f;
  endfunction

  function automatic logic [87:0] mk_word(input logic [19:0] c0, input logic [19:0] c1,
                                          input logic [19:0] c2, input logic [19:0] c3,
                                          input logic [2:0] os, input logic ri);
    return {4'h0, ri, os, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    cfg_valid_i = 1'b1;
    cfg_data_i  = b;
    while (!cfg_ready_o && g < 20) begin
      step();
      g++;
    end
    chk("cfg_accept_timeout", 128'(g < 20), 128'(1));
    step();
  endtask

  task automatic send_frame(input logic [103:0] f);
    for (int i = 0; i < 13; i++) send_byte(f[8*i +: 8]);
    cfg_valid_i = 1'b0;
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  logic [83:0] m_mode  = '0;
  logic [83:0] m_pend  = '0;
  bit          m_ready = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_apply = 1'b0;
  int          m_cnt   = -1;
  logic [7:0]  m_q[$];
  bit          m_tx_busy  = 1'b0;
  bit          m_tx_valid = 1'b0;
  logic [7:0]  m_tx_q[$];
  bit          cmp_en = 1'b0;

  always @(posedge clock_i or negedge reset_i) begin : model
    bit           acc;
    logic [7:0]   x;
    logic [87:0]  w;
    logic [103:0] fr;
    if (!reset_i) begin
      m_mode = '0; m_pend = '0; m_ready = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_apply = 1'b0; m_cnt = -1; m_q.delete();
      m_tx_busy = 1'b0; m_tx_valid = 1'b0; m_tx_q.delete();
    end else begin
      // readback sees the committed word from before this edge
      if (!m_tx_busy) begin
        if (rd_req_i) begin
          m_tx_busy = 1'b1;
          fr = mk_frame({4'h0, m_mode});
          m_tx_q.delete();
          for (int i = 0; i < 13; i++) m_tx_q.push_back(fr[8*i +: 8]);
        end
      end else if (!m_tx_valid) begin
        m_tx_valid = 1'b1;
      end else if (rd_ready_i) begin
        void'(m_tx_q.pop_front());
        if (m_tx_q.size() == 0) begin
          m_tx_valid = 1'b0;
          m_tx_busy  = 1'b0;
        end
      end
      acc = cfg_valid_i && m_ready;
      m_done = 1'b0; m_err = 1'b0; m_ready = 1'b1;
      if (m_apply) begin
        m_mode  = m_pend;
        m_done  = 1'b1;
        m_apply = 1'b0;
      end else if (acc) begin
        if (m_cnt < 0) begin
          if (cfg_data_i == 8'hA5) begin
            m_cnt = 0;
            m_q.delete();
          end
        end else if (m_cnt < 11) begin
          m_q.push_back(cfg_data_i);
          m_cnt++;
        end else begin
          x = 8'h00;
          w = '0;
          for (int i = 0; i < 11; i++) begin
            x ^= m_q[i];
            w[8*i +: 8] = m_q[i];
          end
          if (cfg_data_i == x && w[87:84] == 4'h0) begin
            m_pend  = w[83:0];
            m_apply = 1'b1;
            m_ready = 1'b0;
          end else begin
            m_err = 1'b1;
          end
          m_cnt = -1;
        end
      end
    end
  end

  always @(negedge clock_i) begin
    if (cmp_en) begin
      chk("fields", {register_inputs_o, output_select_o, coeff_3_o, coeff_2_o, coeff_1_o, coeff_0_o}, m_mode);
      chk("cfg_done", cfg_done_o, m_done);
      chk("cfg_error", cfg_error_o, m_err);
      chk("cfg_ready", cfg_ready_o, m_ready);
      chk("rd_valid", rd_valid_o, m_tx_valid);
      if (m_tx_valid && m_tx_q.size() > 0) chk("rd_data", rd_data_o, m_tx_q[0]);
    end
  end

  int         n_done = 0;
  int         n_err  = 0;
  logic [7:0] rb_q[$];

  always @(negedge clock_i) begin
    if (cfg_done_o === 1'b1) n_done++;
    if (cfg_error_o === 1'b1) n_err++;
    if (rd_valid_o === 1'b1 && rd_ready_i) rb_q.push_back(rd_data_o);
  end

  task automatic wait_rb();
    int g;
    g = 0;
    while (rb_q.size() < 13 && g < 200) begin
      step();
      g++;
    end
    chk("readback_timeout", 128'(g < 200), 128'(1));
    repeat (4) step();
    chk("readback_count", 128'(rb_q.size()), 128'(13));
  endtask

  logic [103:0] f_a, f_b, f_bad, f_pad, exp_a;

  initial begin
    f_a = mk_frame(mk_word(20'h12345, 20'hABCDE, 20'h00000, 20'hFFFFF, 3'b101, 1'b1));
    f_b = mk_frame(mk_word(20'h0F0F0, 20'h00001, 20'h80000, 20'h7A5A5, 3'b010, 1'b0));
    exp_a = {8'h1C, 8'h0D, 8'hFF, 8'hFF, 8'hF0, 8'h00, 8'h00,
             8'hAB, 8'hCD, 8'hE1, 8'h23, 8'h45, 8'hA5};

    #1 reset_i = 1'b0;
    cmp_en = 1'b1;
    step(); step();
    chk("rst_fields", {register_inputs_o, output_select_o, coeff_3_o, coeff_2_o, coeff_1_o, coeff_0_o}, 128'(0));
    chk("rst_flags", {cfg_done_o, cfg_error_o, rd_valid_o, cfg_ready_o}, 128'(0));
    chk("rst_rd_data", rd_data_o, 128'(0));
    @(posedge clock_i); #2 reset_i = 1'b1;

    chk("model_frame_a", f_a, exp_a);

    // good frame
    send_frame(f_a);
    step(); step();
    chk("a_coeff0", coeff_0_o, 20'h12345);
    chk("a_coeff1", coeff_1_o, 20'hABCDE);
    chk("a_coeff2", coeff_2_o, 20'h00000);
    chk("a_coeff3", coeff_3_o, 20'hFFFFF);
    chk("a_osel", output_select_o, 3'b101);
    chk("a_regin", register_inputs_o, 1'b1);
    chk("a_done_cnt", 128'(n_done), 128'(1));
    chk("a_err_cnt", 128'(n_err), 128'(0));

    // corrupted checksum
    f_bad = f_a;
    f_bad[103:96] = f_a[103:96] ^ 8'h01;
    send_frame(f_bad);
    step(); step();
    chk("bad_err_cnt", 128'(n_err), 128'(1));
    chk("bad_done_cnt", 128'(n_done), 128'(1));
    chk("bad_coeff1", coeff_1_o, 20'hABCDE);

    // pad bit set, checksum consistent
    f_pad = f_a;
    f_pad[95:88]  = 8'h10;
    f_pad[103:96] = f_a[103:96] ^ f_a[95:88] ^ 8'h10;
    chk("model_pad_csum", f_pad[103:96], 8'h01);
    send_frame(f_pad);
    step(); step();
    chk("pad_err_cnt", 128'(n_err), 128'(2));
    chk("pad_done_cnt", 128'(n_done), 128'(1));
    chk("pad_regin", register_inputs_o, 1'b1);

    // garbage then a valid frame
    send_byte(8'h00);
    send_byte(8'h5A);
    send_frame(f_b);
    step(); step();
    chk("b_done_cnt", 128'(n_done), 128'(2));
    chk("b_err_cnt", 128'(n_err), 128'(2));
    chk("b_coeff0", coeff_0_o, 20'h0F0F0);
    chk("b_coeff3", coeff_3_o, 20'h7A5A5);
    chk("b_osel", output_select_o, 3'b010);
    chk("b_regin", register_inputs_o, 1'b0);

    // reset after payload byte 5 discards the partial frame
    for (int i = 0; i < 7; i++) send_byte(f_a[8*i +: 8]);
    cfg_valid_i = 1'b0;
    #1 reset_i = 1'b0;
    step(); step();
    chk("midrst_fields", {register_inputs_o, output_select_o, coeff_3_o, coeff_2_o, coeff_1_o, coeff_0_o}, 128'(0));
    chk("midrst_ready", cfg_ready_o, 1'b0);
    @(posedge clock_i); #2 reset_i = 1'b1;
    send_frame(f_a);
    step(); step();
    chk("fresh_done_cnt", 128'(n_done), 128'(3));
    chk("fresh_coeff3", coeff_3_o, 20'hFFFFF);

    // readback with toggling ready while frame B commits mid-stream
    rb_q.delete();
    rd_ready_i = 1'b0;
    fork
      begin
        rd_req_i = 1'b1;
        repeat (4) step();
        rd_req_i = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          step();
          rd_ready_i = ~rd_ready_i;
        end
      end
      begin
        repeat (3) step();
        send_frame(f_b);
      end
    join
    rd_ready_i = 1'b1;
    wait_rb();
    for (int i = 0; i < 13 && i < rb_q.size(); i++)
      chk($sformatf("rb_a_byte%0d", i), rb_q[i], exp_a[8*i +: 8]);
    chk("rb_commit_done_cnt", 128'(n_done), 128'(4));
    chk("rb_commit_coeff0", coeff_0_o, 20'h0F0F0);

    // second readback returns the newly committed word
    rb_q.delete();
    rd_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    wait_rb();
    for (int i = 0; i < 13 && i < rb_q.size(); i++)
      chk($sformatf("rb_b_byte%0d", i), rb_q[i], f_b[8*i +: 8]);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
